// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: multiply/divide op encoding and FSM states
package cpu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, b_q};
    acc_d    = acc_q;
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_q_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                acc_q    <= {{WIDTH{1'b0}}, a_abs};
                b_q      <= b_abs;
                is_div_q <= op[1];
                neg_q_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_q  <= signed_op & a[WIDTH-1];
                dz_q     <= (b == '0);
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= ST_RUN;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          // divide by zero leaves the dividend as remainder, so only the quotient needs forcing
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= dz_q ? {WIDTH{1'b1}} : quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit at WIDTH=32 and WIDTH=8
module tb_mul_div_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        sel8;

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        busy_s, done_s;
  logic [31:0] hi_s, lo_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel8), .op(op), .a(a), .b(b),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & sel8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign hi_s   = sel8 ? {24'b0, hi8} : hi32;
  assign lo_s   = sel8 ? {24'b0, lo8} : lo32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended operands, result as {hi, lo}
  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    longint unsigned mask, ux, uy, p;
    longint sx, sy, q, r;
    logic [31:0] rh, rl;
    mask = (64'd1 << w) - 64'd1;
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    sx = x[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy = y[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      3'd0, 3'd1: begin
        p  = (o == 3'd0) ? longint'(sx * sy) : ux * uy;
        rh = 32'((p >> w) & mask);
        rl = 32'(p & mask);
      end
      default: begin
        if (uy == 0) begin
          rh = 32'(ux);
          rl = 32'(mask);
        end else if (o == 3'd2) begin
          q  = sx / sy;
          r  = sx % sy;
          rh = 32'(longint'(r) & mask);
          rl = 32'(longint'(q) & mask);
        end else begin
          rh = 32'(ux % uy);
          rl = 32'(ux / uy);
        end
      end
    endcase
    return {rh, rl};
  endfunction

  task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit inject);
    int w, k, lat;
    bit ok;
    logic [63:0] e;
    logic [31:0] mask;
    w    = w8 ? 8 : 32;
    k    = w8 ? 1 : 0;
    mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
    sel8 = w8;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    if (o >= 3'd4) begin
      if (o == OP_MTHI) m_hi[k] = x & mask;
      if (o == OP_MTLO) m_lo[k] = x & mask;
      chk("move_hi", hi_s, m_hi[k]);
      chk("move_lo", lo_s, m_lo[k]);
      chk("move_busy_done", {busy_s, done_s}, 2'b00);
    end else begin
      e = model(w, o, x, y);
      chk("busy_after_e0", busy_s, 1'b1);
      ok  = 1'b1;
      lat = 0;
      for (int i = 1; i <= 2 * w + 8 && lat == 0; i++) begin
        if (inject && i == 5) begin
          start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (done_s) lat = i;
        else if (!busy_s || hi_s !== m_hi[k] || lo_s !== m_lo[k]) ok = 1'b0;
      end
      m_hi[k] = e[63:32];
      m_lo[k] = e[31:0];
      chk("busy_and_hold_in_run", ok, 1'b1);
      chk("latency", lat, w + 1);
      chk("busy_clear_at_done", busy_s, 1'b0);
      chk("hi_result", hi_s, m_hi[k]);
      chk("lo_result", lo_s, m_lo[k]);
    end
  endtask

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    logic [31:0] x;
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; sel8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy32, done32, hi32, lo32}, 66'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // abort a multiply mid-flight
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_op", {busy32, done32, hi32, lo32}, 66'd0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32 || busy32) pulses++;
    end
    chk("no_activity_after_abort", pulses, 0);

    run(0, OP_MULTU, 32'd5, 32'd7, 0);
    run(0, OP_MULT,  32'hFFFF_FFFE, 32'd3, 0);
    run(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(0, OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(0, OP_DIVU,  32'd100, 32'd7, 0);
    run(0, OP_DIVU,  32'h1234, 32'd0, 0);
    run(0, OP_DIV,   32'hFFFF_FF00, 32'd0, 0);
    run(0, OP_MULTU, 32'd1000, 32'd1000, 1);
    run(0, OP_MTHI,  32'hDEAD_BEEF, 32'd0, 0);
    run(0, OP_MTLO,  32'd1, 32'd0, 0);
    run(0, 3'd6,     32'h5555_5555, 32'd0, 0);
    run(0, 3'd7,     32'hAAAA_AAAA, 32'd0, 0);
    for (int i = 0; i < 30; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      run(0, 3'($urandom_range(0, 7)), x, pick_b(), $urandom_range(0, 3) == 0);
    end

    run(1, OP_MULTU, 32'hFF, 32'hFF, 0);
    run(1, OP_DIV,   32'h80, 32'hFF, 0);
    for (int i = 0; i < 15; i++) begin
      run(1, 3'($urandom_range(0, 7)), $urandom, pick_b(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit that sits beside the execute-stage ALU of the pipelined CPU and owns the HI/LO register pair. It accepts one operation at a time through a start/busy handshake, computes products and quotient/remainder one bit per cycle, and exposes HI/LO for move-from instructions. The hazard unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width and width of HI and LO; must be at least 4.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request; sampled only when `busy`=0.
- `op`  input  3: operation code (package constants): MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are no-ops.
- `a`  input  WIDTH: rs operand (multiplicand or dividend; source for MTHI/MTLO).
- `b`  input  WIDTH: rt operand (multiplier or divisor).
- `busy`  output  1: operation in flight; new starts are ignored.
- `done`  output  1: one-cycle pulse when HI/LO have just been updated by a mul/div.
- `hi`  output  WIDTH: HI register (product upper half or remainder).
- `lo`  output  WIDTH: LO register (product lower half or quotient).

## Operation
- FSM states: IDLE, RUN, FIX. Reset puts the FSM in IDLE with `busy`=0, `done`=0, `hi`=0, `lo`=0, and the iteration counter at 0.
- IDLE with `start`=1:
  - MULT/MULTU/DIV/DIVU latch the operands and go to RUN.
  - Signed ops latch absolute values and record the result signs: product sign = sign(a) XOR sign(b); quotient sign = same; remainder sign = sign(a).
  - MTHI/MTLO write `a` into `hi`/`lo` at that edge, stay in IDLE, and do not pulse `done`.
  - Codes 6–7 are ignored.
- RUN lasts exactly WIDTH cycles with a counter from 0 to WIDTH-1.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX (1 cycle):
  - Negate the results as required by the recorded signs.
  - Write `hi`/`lo`.
  - Register `done`=1 and return to IDLE.
- Division rules:
  - Truncation is toward zero.
  - A divisor of 0 gives `lo`=all ones and `hi`=`a`, with the same latency.
  - Signed MIN/−1 gives `lo`=MIN and `hi`=0.
- `hi`/`lo` hold their previous values throughout RUN. Reading them while `busy`=1 returns old data; preventing this is the stall logic's job.
- Reset asserted mid-operation aborts the operation immediately. The partial result is discarded and all outputs return to their reset values.

## Timing
- A start is accepted at edge E0. `busy`=1 from after E0 through edge E(WIDTH+1).
- At E(WIDTH+1): `hi`/`lo` are updated, `done`=1 for exactly one cycle, and `busy`=0.
- Total latency is WIDTH+1 cycles after acceptance. This is 33 cycles for WIDTH=32.
- `start` in the same cycle that `done` is high is accepted, since `busy`=0 then. Back-to-back operations therefore have no idle gap.
- MTHI/MTLO take effect at E0 with zero latency and never raise `busy`.
- `start` while `busy`=1 is dropped, not queued.
- `busy` and `done` are registered outputs with no combinational path from the inputs.

## Structure
- Shared package `cpu_pkg` holds:
  - the op encoding constants;
  - the FSM state typedef;
  - the `MDU_OP_W`=3 constant, for reuse by the decoder.
- Single module. No sub-module is warranted: the mul and div datapaths share the accumulator and counter.

## Test plan
- Reset mid-operation: start MULTU a=5, b=7, assert `rst_n`=0 at cycle 10, release → `hi`=`lo`=0, `busy`=0, no `done` pulse; a new MULTU 5×7 then gives `lo`=35, `hi`=0 at E33.
- Signed multiply: MULT a=0xFFFFFFFE (−2), b=3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `done` exactly at E33, `busy` high for 33 cycles. MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed divide:
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 100/7 → `lo`=14, `hi`=2.
- Divide by zero: DIVU a=0x1234, b=0 → `lo`=0xFFFFFFFF, `hi`=0x1234, with normal 33-cycle latency.
- Handshake:
  - A second `start` at cycle 5 of an operation is ignored and the first result is unaffected.
  - `start` in the `done` cycle is accepted, and its `done` follows 33 cycles later.
- Move-to: MTHI a=0xDEADBEEF, then MTLO a=1 on the next cycle → `hi`/`lo` update on each edge, `busy` stays 0, no `done`. Repeat with WIDTH=8 for MULTU 0xFF×0xFF → `hi`=0xFE, `lo`=0x01 at E9.
